lock_ctrl_fsm: RTL and testbench

Lock-policy controller that drives the `not_lock_status` / `lock_override` pair consumed by the protected 16-bit locked configuration register.
- Holds a sticky lock that only reset can clear.
- Grants a bounded-duration debug override after a correct key is presented.
- Counts bad keys and, when configured, enters a permanent lockout.
- Flags write attempts made while the register is protected.

---
 rtl/lock_ctrl_fsm_if.sv | 28 ++
 rtl/lock_ctrl_fsm.sv | 138 +++++++++++++
 tb/tb_lock_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lock_ctrl_fsm_if.sv
// rtl/lock_ctrl_fsm_if.sv - key/lock request and status bundle for lock_ctrl_fsm
interface lock_ctrl_fsm_if #(
  parameter int KEY_WIDTH = 16,
  parameter int FAIL_W    = 2
);
  logic                 lock_req;
  logic                 key_valid;
  logic [KEY_WIDTH-1:0] key_in;
  logic                 override_exit;
  logic                 write_attempt;
  logic                 not_lock_status;
  logic                 lock_override;
  logic                 key_ack;
  logic                 key_ok;
  logic [FAIL_W-1:0]    fail_count;
  logic                 lockout;
  logic                 violation;

  modport master (
    output lock_req, key_valid, key_in, override_exit, write_attempt,
    input  not_lock_status, lock_override, key_ack, key_ok, fail_count, lockout, violation
  );

  modport slave (
    input  lock_req, key_valid, key_in, override_exit, write_attempt,
    output not_lock_status, lock_override, key_ack, key_ok, fail_count, lockout, violation
  );
endinterface

// File: rtl/lock_ctrl_fsm.sv
// rtl/lock_ctrl_fsm.sv - lock-policy controller; LOCK_CTRL_LOCKOUT_EN enables permanent lockout
module lock_ctrl_fsm #(
  parameter int                   KEY_WIDTH       = 16,
  parameter logic [KEY_WIDTH-1:0] UNLOCK_KEY      = 16'hA5C3,
  parameter int                   MAX_FAIL        = 3,
  parameter int                   OVERRIDE_CYCLES = 64
) (
  input logic             clk,
  input logic             resetn,
  lock_ctrl_fsm_if.slave  bus
);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int TIMER_W = (OVERRIDE_CYCLES > 1) ? $clog2(OVERRIDE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(OVERRIDE_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX   = FAIL_W'(MAX_FAIL);

`ifdef LOCK_CTRL_LOCKOUT_EN
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_OVERRIDE = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_OVERRIDE = 2'd2
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [FAIL_W-1:0]    fail_q, fail_d;
  logic                 nls_q, nls_d;
  logic                 ovr_q, ovr_d;
  logic                 lockout_q, lockout_d;
  logic                 ack_q, ack_d;
  logic                 ok_q, ok_d;
  logic                 viol_q, viol_d;
  logic                 key_match;

  // Full-width compare: a key differing in any bit is a failure.
  assign key_match = (bus.key_in == UNLOCK_KEY);

  // State, timer, counter and every output are flops cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_UNLOCKED;
      timer_q   <= '0;
      fail_q    <= '0;
      nls_q     <= 1'b1;
      ovr_q     <= 1'b0;
      lockout_q <= 1'b0;
      ack_q     <= 1'b0;
      ok_q      <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      fail_q    <= fail_d;
      nls_q     <= nls_d;
      ovr_q     <= ovr_d;
      lockout_q <= lockout_d;
      ack_q     <= ack_d;
      ok_q      <= ok_d;
      viol_q    <= viol_d;
    end
  end

  // Next-state policy; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    ack_d   = bus.key_valid;
    ok_d    = 1'b0;
    // Protection is judged from what the register currently sees, i.e. the registered pair.
    viol_d  = bus.write_attempt && !nls_q && !ovr_q;

    case (state_q)
      ST_UNLOCKED: begin
        // A key arriving with the lock request is only acknowledged, never evaluated.
        if (bus.lock_req) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (bus.key_valid) begin
          if (key_match) begin
            state_d = ST_OVERRIDE;
            ok_d    = 1'b1;
            fail_d  = '0;
            timer_d = TIMER_LOAD;
          end else begin
            if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
`ifdef LOCK_CTRL_LOCKOUT_EN
            if (fail_d == FAIL_MAX) state_d = ST_LOCKOUT;
`endif
          end
        end
      end
      ST_OVERRIDE: begin
        // Timer holds remaining cycles minus one, so the override spans OVERRIDE_CYCLES edges.
        if (timer_q == '0 || bus.override_exit) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef LOCK_CTRL_LOCKOUT_EN
      ST_LOCKOUT: begin
        state_d = ST_LOCKOUT;
      end
`endif
      default: begin
        // Unreachable encodings fall back to protected, never to unlocked.
        state_d = ST_LOCKED;
        timer_d = '0;
      end
    endcase

    nls_d = (state_d == ST_UNLOCKED);
    ovr_d = (state_d == ST_OVERRIDE);
`ifdef LOCK_CTRL_LOCKOUT_EN
    lockout_d = (state_d == ST_LOCKOUT);
`else
    lockout_d = 1'b0;
`endif
  end

  assign bus.not_lock_status = nls_q;
  assign bus.lock_override   = ovr_q;
  assign bus.key_ack         = ack_q;
  assign bus.key_ok          = ok_q;
  assign bus.fail_count      = fail_q;
  assign bus.lockout         = lockout_q;
  assign bus.violation       = viol_q;
endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// tb/tb_lock_ctrl_fsm.sv - vector, corner-case and randomized-model bench for lock_ctrl_fsm
module tb_lock_ctrl_fsm;
  localparam int          OC = 64;
  localparam int          MF = 3;
  localparam logic [15:0] UK = 16'hA5C3;
`ifdef LOCK_CTRL_LOCKOUT_EN
  localparam bit LO_EN = 1'b1;
`else
  localparam bit LO_EN = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  lock_ctrl_fsm_if #(.KEY_WIDTH(16), .FAIL_W(2)) bus ();

  lock_ctrl_fsm #(
    .KEY_WIDTH(16), .UNLOCK_KEY(UK), .MAX_FAIL(MF), .OVERRIDE_CYCLES(OC)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lock flag, remaining override cycles, failure tally, lockout flag.
  bit m_locked, m_lockout, m_ack, m_ok, m_viol;
  int m_ovr_left, m_fails;

  typedef struct {
    logic lr; logic kv; logic [15:0] key; logic ex; logic wr;
    logic e_nls; logic e_ovr; logic e_ack; logic e_ok; logic [1:0] e_fc; logic e_lo; logic e_viol;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_lockout = 0; m_ack = 0; m_ok = 0; m_viol = 0;
    m_ovr_left = 0; m_fails = 0;
  endtask

  task automatic model_step(input logic lr, kv, input logic [15:0] key, input logic ex, wr);
    m_viol = wr && m_locked && (m_ovr_left == 0);
    m_ack  = kv;
    m_ok   = 0;
    if (!m_locked) begin
      if (lr) m_locked = 1;
    end else if (m_lockout) begin
      // terminal
    end else if (m_ovr_left > 0) begin
      m_ovr_left = ex ? 0 : m_ovr_left - 1;
    end else if (kv) begin
      if (key == UK) begin
        m_ok = 1; m_fails = 0; m_ovr_left = OC;
      end else begin
        if (m_fails < MF) m_fails = m_fails + 1;
        if (LO_EN && m_fails == MF) m_lockout = 1;
      end
    end
  endtask

  task automatic check_model();
    chk("model_nls",   {31'd0, bus.not_lock_status}, {31'd0, !m_locked});
    chk("model_ovr",   {31'd0, bus.lock_override},   {31'd0, m_ovr_left > 0});
    chk("model_ack",   {31'd0, bus.key_ack},         {31'd0, m_ack});
    chk("model_ok",    {31'd0, bus.key_ok},          {31'd0, m_ok});
    chk("model_fc",    {30'd0, bus.fail_count},      m_fails);
    chk("model_lo",    {31'd0, bus.lockout},         {31'd0, m_lockout});
    chk("model_viol",  {31'd0, bus.violation},       {31'd0, m_viol});
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic lr, kv, input logic [15:0] key, input logic ex, wr);
    bus.lock_req = lr; bus.key_valid = kv; bus.key_in = key;
    bus.override_exit = ex; bus.write_attempt = wr;
    @(posedge clk);
    model_step(lr, kv, key, ex, wr);
    @(negedge clk);
  endtask

  task automatic step(input logic lr, kv, input logic [15:0] key, input logic ex, wr);
    drive(lr, kv, key, ex, wr);
    check_model();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.lock_req = 0; bus.key_valid = 0; bus.key_in = '0;
    bus.override_exit = 0; bus.write_attempt = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic enter_override();
    step(1, 0, 16'h0, 0, 0);
    step(0, 1, UK, 0, 0);
    chk("ovr_entry", {31'd0, bus.lock_override}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           lr kv key       ex wr  nls ovr ack ok  fc               lo     viol
    vecs[0]  = '{0, 0, 16'h0000, 0, 0,  1,  0,  0,  0,  2'd0,            1'b0,  0};
    vecs[1]  = '{0, 0, 16'h0000, 0, 1,  1,  0,  0,  0,  2'd0,            1'b0,  0};
    vecs[2]  = '{0, 1, UK,       0, 0,  1,  0,  1,  0,  2'd0,            1'b0,  0};
    vecs[3]  = '{1, 0, 16'h0000, 0, 0,  0,  0,  0,  0,  2'd0,            1'b0,  0};
    vecs[4]  = '{0, 0, 16'h0000, 0, 1,  0,  0,  0,  0,  2'd0,            1'b0,  1};
    vecs[5]  = '{0, 1, 16'hA5C2, 0, 0,  0,  0,  1,  0,  2'd1,            1'b0,  0};
    vecs[6]  = '{0, 1, 16'h0000, 0, 0,  0,  0,  1,  0,  2'd2,            1'b0,  0};
    vecs[7]  = '{0, 1, 16'h0000, 0, 1,  0,  0,  1,  0,  2'd3,            LO_EN, 1};
    vecs[8]  = '{0, 1, UK,       0, 0,  0,  !LO_EN, 1, !LO_EN, LO_EN ? 2'd3 : 2'd0, LO_EN, 0};
    vecs[9]  = '{0, 0, 16'h0000, 0, 1,  0,  !LO_EN, 0, 0, LO_EN ? 2'd3 : 2'd0, LO_EN, LO_EN};
    vecs[10] = '{1, 0, 16'h0000, 0, 0,  0,  !LO_EN, 0, 0, LO_EN ? 2'd3 : 2'd0, LO_EN, 0};

    resetn = 1'b0;
    do_reset();
    chk("reset_nls", {31'd0, bus.not_lock_status}, 32'd1);
    chk("reset_ovr", {31'd0, bus.lock_override},   32'd0);
    chk("reset_ack", {31'd0, bus.key_ack},         32'd0);
    chk("reset_fc",  {30'd0, bus.fail_count},      32'd0);
    chk("reset_lo",  {31'd0, bus.lockout},         32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].lr, vecs[i].kv, vecs[i].key, vecs[i].ex, vecs[i].wr);
      chk($sformatf("vec%0d_nls", i),  {31'd0, bus.not_lock_status}, {31'd0, vecs[i].e_nls});
      chk($sformatf("vec%0d_ovr", i),  {31'd0, bus.lock_override},   {31'd0, vecs[i].e_ovr});
      chk($sformatf("vec%0d_ack", i),  {31'd0, bus.key_ack},         {31'd0, vecs[i].e_ack});
      chk($sformatf("vec%0d_ok", i),   {31'd0, bus.key_ok},          {31'd0, vecs[i].e_ok});
      chk($sformatf("vec%0d_fc", i),   {30'd0, bus.fail_count},      {30'd0, vecs[i].e_fc});
      chk($sformatf("vec%0d_lo", i),   {31'd0, bus.lockout},         {31'd0, vecs[i].e_lo});
      chk($sformatf("vec%0d_viol", i), {31'd0, bus.violation},       {31'd0, vecs[i].e_viol});
    end

    // Override lasts exactly OC cycles; writes during it raise no violation.
    begin
      int cnt = 0;
      int viol_seen = 0;
      do_reset();
      enter_override();
      chk("ovr_key_ok", {31'd0, bus.key_ok}, 32'd1);
      for (int i = 0; i < 200; i++) begin
        if (!bus.lock_override) break;
        cnt++;
        step(0, 0, 16'h0, 0, 1);
        if (bus.violation) viol_seen++;
      end
      chk("ovr_len", cnt, OC);
      chk("ovr_no_viol", viol_seen, 0);
      chk("ovr_after_nls", {31'd0, bus.not_lock_status}, 32'd0);
    end

    // Early exit at the tenth override cycle.
    do_reset();
    enter_override();
    repeat (9) step(0, 0, 16'h0, 0, 0);
    chk("exit_pre_ovr", {31'd0, bus.lock_override}, 32'd1);
    step(0, 0, 16'h0, 1, 0);
    chk("exit_ovr", {31'd0, bus.lock_override},   32'd0);
    chk("exit_nls", {31'd0, bus.not_lock_status}, 32'd0);
    step(0, 0, 16'h0, 0, 1);
    chk("exit_viol", {31'd0, bus.violation}, 32'd1);

    // Lock request and correct key together while unlocked.
    do_reset();
    step(1, 1, UK, 0, 0);
    chk("sim_nls", {31'd0, bus.not_lock_status}, 32'd0);
    chk("sim_ack", {31'd0, bus.key_ack},         32'd1);
    chk("sim_ok",  {31'd0, bus.key_ok},          32'd0);
    chk("sim_ovr", {31'd0, bus.lock_override},   32'd0);
    step(0, 0, 16'h0, 0, 0);
    chk("sim_ovr2", {31'd0, bus.lock_override}, 32'd0);

    // Failure count saturates.
    do_reset();
    step(1, 0, 16'h0, 0, 0);
    repeat (5) step(0, 1, 16'h1111, 0, 0);
    chk("sat_fc", {30'd0, bus.fail_count}, MF);

    // Asynchronous reset mid-override, then mid-count.
    do_reset();
    enter_override();
    repeat (5) step(0, 0, 16'h0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    chk("areset_nls", {31'd0, bus.not_lock_status}, 32'd1);
    chk("areset_ovr", {31'd0, bus.lock_override},   32'd0);
    chk("areset_fc",  {30'd0, bus.fail_count},      32'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    step(1, 0, 16'h0, 0, 0);
    step(0, 1, 16'h0, 0, 0);
    step(0, 1, 16'h0, 0, 0);
    chk("pre_areset_fc", {30'd0, bus.fail_count}, 32'd2);
    #2 resetn = 1'b0;
    #1;
    chk("areset2_fc",  {30'd0, bus.fail_count},      32'd0);
    chk("areset2_nls", {31'd0, bus.not_lock_status}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic        lr, kv, ex, wr;
      logic [15:0] key;
      int          r;
      if (c % 400 == 0) do_reset();
      lr = ($urandom_range(0, 7) == 0);
      kv = ($urandom_range(0, 2) == 0);
      ex = ($urandom_range(0, 19) == 0);
      wr = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 3);
      if (r < 2)       key = UK;
      else if (r == 2) key = UK ^ (16'h1 << $urandom_range(0, 15));
      else             key = 16'($urandom);
      step(lr, kv, key, ex, wr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
